// File: rtl/nfc_acs_pkg.sv
// Shared constants for the atom command/address sender: state encoding,
// ACG bus bit position, address byte limit and default NAND bus timing.
package nfc_acs_pkg;

    localparam int ACG_CMD_BIT    = 3;
    localparam int MAX_ADDR_BYTES = 5;

    localparam int DEF_TCS = 2;
    localparam int DEF_TWP = 2;
    localparam int DEF_TWH = 2;
    localparam int DEF_TCH = 2;

    localparam int STATE_W = 6;
    localparam logic [STATE_W-1:0] ST_IDLE   = 6'b000001;
    localparam logic [STATE_W-1:0] ST_SETUP  = 6'b000010;
    localparam logic [STATE_W-1:0] ST_WELOW  = 6'b000100;
    localparam logic [STATE_W-1:0] ST_WEHIGH = 6'b001000;
    localparam logic [STATE_W-1:0] ST_HOLD   = 6'b010000;
    localparam logic [STATE_W-1:0] ST_DONE   = 6'b100000;

    // Address requests beyond the byte limit saturate rather than wrap.
    function automatic logic [2:0] byte_count(input logic ca_select,
                                              input logic [15:0] num_of_data);
        if (ca_select)
            return 3'd1;
        if (num_of_data >= 16'(MAX_ADDR_BYTES - 1))
            return 3'(MAX_ADDR_BYTES);
        return num_of_data[2:0] + 3'd1;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/nfc_timing_counter.sv
// Loadable down-counter; tc is high once the loaded phase length has elapsed.
module nfc_timing_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign tc = (count == '0);

endmodule

// File: rtl/nfc_atom_command_sync_sender.sv
// Turns one command/address request into NAND CLE/ALE latch cycles with
// programmable setup, WE_n low/high and hold timing.
//
// state  | meaning
// IDLE   | ready, waiting for start
// SETUP  | CE_n/CLE/ALE/DQ set up before first WE_n fall
// WELOW  | WE_n low, DQ stable
// WEHIGH | WE_n high, NAND latches byte on rise
// HOLD   | hold after last WE_n rise, pins still asserted
// DONE   | pins released, LastStep pulse
module nfc_atom_command_sync_sender
    import nfc_acs_pkg::*;
#(
    parameter int NumberOfWays = 4,
    parameter int TCS          = DEF_TCS,
    parameter int TWP          = DEF_TWP,
    parameter int TWH          = DEF_TWH,
    parameter int TCH          = DEF_TCH
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic                    iStart,
    output logic                    oReady,
    output logic                    oLastStep,
    input  logic [NumberOfWays-1:0] iTargetWay,
    input  logic                    iCASelect,
    input  logic [39:0]             iCAData,
    input  logic [15:0]             iNumOfData,
    output logic [7:0]              oDQ,
    output logic                    oDQOutEnable,
    output logic                    oCLE,
    output logic                    oALE,
    output logic                    oWE_n,
    output logic [NumberOfWays-1:0] oCE_n
);

    localparam int CNT_W = $clog2(max4(TCS, TWP, TWH, TCH)) + 1;

    logic [STATE_W-1:0]      state, state_nxt;
    logic [NumberOfWays-1:0] way, way_nxt;
    logic                    ca_sel, ca_sel_nxt;
    logic [39:0]             data, data_nxt;
    logic [2:0]              bytes_left, bytes_left_nxt;
    logic                    cnt_load;
    logic [CNT_W-1:0]        cnt_value;
    logic                    cnt_tc;
    logic                    active_nxt;

    nfc_timing_counter #(.WIDTH(CNT_W)) u_timer (
        .clock      (iSystemClock),
        .reset      (iReset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .tc         (cnt_tc)
    );

    always_comb begin
        state_nxt      = state;
        way_nxt        = way;
        ca_sel_nxt     = ca_sel;
        data_nxt       = data;
        bytes_left_nxt = bytes_left;
        cnt_load       = 1'b0;
        cnt_value      = '0;
        case (state)
            ST_IDLE: if (iStart) begin
                state_nxt      = ST_SETUP;
                way_nxt        = iTargetWay;
                ca_sel_nxt     = iCASelect;
                data_nxt       = iCAData;
                bytes_left_nxt = byte_count(iCASelect, iNumOfData);
                cnt_load       = 1'b1;
                cnt_value      = CNT_W'(TCS - 1);
            end
            ST_SETUP: if (cnt_tc) begin
                state_nxt = ST_WELOW;
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(TWP - 1);
            end
            ST_WELOW: if (cnt_tc) begin
                state_nxt = ST_WEHIGH;
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(TWH - 1);
            end
            // The last byte stays on DQ through HOLD, so only shift when another follows.
            ST_WEHIGH: if (cnt_tc) begin
                cnt_load = 1'b1;
                if (bytes_left > 3'd1) begin
                    state_nxt      = ST_WELOW;
                    data_nxt       = {data[31:0], 8'h00};
                    bytes_left_nxt = bytes_left - 3'd1;
                    cnt_value      = CNT_W'(TWP - 1);
                end else begin
                    state_nxt = ST_HOLD;
                    cnt_value = CNT_W'(TCH - 1);
                end
            end
            ST_HOLD:  if (cnt_tc) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign active_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_WELOW) ||
                        (state_nxt == ST_WEHIGH) || (state_nxt == ST_HOLD);

    // Pins are computed from the next state so every output leaves a flop.
    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state        <= ST_IDLE;
            way          <= '0;
            ca_sel       <= 1'b0;
            data         <= '0;
            bytes_left   <= '0;
            oReady       <= 1'b1;
            oLastStep    <= 1'b0;
            oDQ          <= 8'h00;
            oDQOutEnable <= 1'b0;
            oCLE         <= 1'b0;
            oALE         <= 1'b0;
            oWE_n        <= 1'b1;
            oCE_n        <= '1;
        end else begin
            state        <= state_nxt;
            way          <= way_nxt;
            ca_sel       <= ca_sel_nxt;
            data         <= data_nxt;
            bytes_left   <= bytes_left_nxt;
            oReady       <= (state_nxt == ST_IDLE);
            oLastStep    <= (state_nxt == ST_DONE);
            oDQ          <= active_nxt ? data_nxt[39:32] : 8'h00;
            oDQOutEnable <= active_nxt;
            oCLE         <= active_nxt & ca_sel_nxt;
            oALE         <= active_nxt & ~ca_sel_nxt;
            oWE_n        <= (state_nxt != ST_WELOW);
            oCE_n        <= active_nxt ? ~way_nxt : '1;
        end
    end

endmodule

// File: tb/tb_nfc_atom_command_sync_sender.sv
// Bench for the atom command/address sender: per-cycle pin traces are built
// from the bus timing rules and compared against two differently timed instances.
module tb_nfc_atom_command_sync_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [3:0]  way;
    logic        casel;
    logic [39:0] data;
    logic [15:0] nod;

    logic       ready_a, last_a, oe_a, cle_a, ale_a, we_a;
    logic [7:0] dq_a;
    logic [3:0] ce_a;
    logic       ready_b, last_b, oe_b, cle_b, ale_b, we_b;
    logic [7:0] dq_b;
    logic [3:0] ce_b;

    logic [17:0] snap_a, snap_b;

    int errors = 0;
    int checks = 0;

    localparam logic [17:0] IDLE_VEC = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF};
    localparam logic [17:0] DONE_VEC = {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF};

    always #5 clk = ~clk;

    nfc_atom_command_sync_sender dut_a (
        .iSystemClock (clk),      .iReset       (rst),
        .iStart       (start_a),  .oReady       (ready_a),
        .oLastStep    (last_a),   .iTargetWay   (way),
        .iCASelect    (casel),    .iCAData      (data),
        .iNumOfData   (nod),      .oDQ          (dq_a),
        .oDQOutEnable (oe_a),     .oCLE         (cle_a),
        .oALE         (ale_a),    .oWE_n        (we_a),
        .oCE_n        (ce_a)
    );

    nfc_atom_command_sync_sender #(.TCS(1), .TWP(1), .TWH(1), .TCH(1)) dut_b (
        .iSystemClock (clk),      .iReset       (rst),
        .iStart       (start_b),  .oReady       (ready_b),
        .oLastStep    (last_b),   .iTargetWay   (way),
        .iCASelect    (casel),    .iCAData      (data),
        .iNumOfData   (nod),      .oDQ          (dq_b),
        .oDQOutEnable (oe_b),     .oCLE         (cle_b),
        .oALE         (ale_b),    .oWE_n        (we_b),
        .oCE_n        (ce_b)
    );

    assign snap_a = {ready_a, last_a, dq_a, oe_a, cle_a, ale_a, we_a, ce_a};
    assign snap_b = {ready_b, last_b, dq_b, oe_b, cle_b, ale_b, we_b, ce_b};

    function automatic logic [17:0] pin(input logic [7:0] dq, input logic cs,
                                        input logic we_n, input logic [3:0] w);
        return {1'b0, 1'b0, dq, 1'b1, cs, ~cs, we_n, ~w};
    endfunction

    task automatic check(input string tag, input int k, input logic [17:0] obs,
                         input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) start_a = v;
        else           start_b = v;
    endtask

    // mode: 0 single pulse, 1 start held, 2 start toggled randomly while busy
    task automatic run_seq(input int inst, input string tag, input logic [3:0] w,
                           input logic cs, input logic [39:0] d, input logic [15:0] nd,
                           input int mode, input int abort_at);
        int tcs, twp, twh, tch, n;
        logic [17:0] q[$];
        logic [7:0]  b;
        logic [17:0] obs;
        if (inst == 0) begin tcs = 2; twp = 2; twh = 2; tch = 2; end
        else           begin tcs = 1; twp = 1; twh = 1; tch = 1; end
        n = cs ? 1 : ((nd > 16'd4) ? 5 : int'(nd) + 1);
        q.delete();
        b = d[39:32];
        repeat (tcs) q.push_back(pin(b, cs, 1'b1, w));
        for (int i = 0; i < n; i++) begin
            b = d[39-8*i -: 8];
            repeat (twp) q.push_back(pin(b, cs, 1'b0, w));
            repeat (twh) q.push_back(pin(b, cs, 1'b1, w));
        end
        repeat (tch) q.push_back(pin(b, cs, 1'b1, w));
        q.push_back(DONE_VEC);
        q.push_back(IDLE_VEC);
        q.push_back(IDLE_VEC);

        @(negedge clk);
        way = w; casel = cs; data = d; nod = nd;
        set_start(inst, 1'b1);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            obs = (inst == 0) ? snap_a : snap_b;
            check(tag, k, obs, q[k]);
            if (k == abort_at) begin
                rst = 1'b1;
                set_start(inst, 1'b0);
                #1;
                obs = (inst == 0) ? snap_a : snap_b;
                check({tag, "_abort"}, k, obs, IDLE_VEC);
                @(negedge clk);
                obs = (inst == 0) ? snap_a : snap_b;
                check({tag, "_inreset"}, k + 1, obs, IDLE_VEC);
                rst = 1'b0;
                @(negedge clk);
                obs = (inst == 0) ? snap_a : snap_b;
                check({tag, "_released"}, k + 2, obs, IDLE_VEC);
                return;
            end
            if (k >= q.size() - 2)  set_start(inst, 1'b0);
            else if (mode == 0)     set_start(inst, 1'b0);
            else if (mode == 1)     set_start(inst, 1'b1);
            else                    set_start(inst, 1'($urandom_range(0, 1)));
            if (k < q.size() - 2) begin
                way   = 4'($urandom);
                casel = 1'($urandom);
                data  = {$urandom, 8'($urandom)};
                nod   = 16'($urandom);
            end
        end
    endtask

    initial begin
        logic [3:0]  rw;
        logic        rc;
        logic [39:0] rd;
        logic [15:0] rn;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        way = '0; casel = 1'b0; data = '0; nod = '0;
        repeat (3) @(negedge clk);
        check("reset_a", 0, snap_a, IDLE_VEC);
        check("reset_b", 0, snap_b, IDLE_VEC);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_a", 1, snap_a, IDLE_VEC);

        run_seq(0, "cmd60",      4'b0001, 1'b1, 40'h60_00_00_00_00, 16'h0000, 0, -1);
        run_seq(0, "addr5",      4'b0010, 1'b0, 40'h11_22_33_44_55, 16'h0004, 0, -1);
        run_seq(0, "addr_sat",   4'b0100, 1'b0, 40'h11_22_33_44_55, 16'h00FF, 1, -1);
        run_seq(0, "addr1",      4'b1000, 1'b0, 40'hA5_00_00_00_00, 16'h0000, 2, -1);
        run_seq(0, "way_none",   4'b0000, 1'b1, 40'hFF_12_34_56_78, 16'h0003, 0, -1);
        run_seq(1, "cmdD0_fast", 4'b1010, 1'b1, 40'hD0_00_00_00_00, 16'h0000, 0, -1);
        run_seq(1, "addr3_fast", 4'b0110, 1'b0, 40'hC1_C2_C3_C4_C5, 16'h0002, 1, -1);

        for (int i = 0; i < 8; i++) begin
            rw = 4'($urandom);
            rc = 1'($urandom);
            rd = {$urandom, 8'($urandom)};
            rn = (i % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
            run_seq(i % 2, "random", rw, rc, rd, rn, 2, -1);
        end

        // abort on the first cycle of the third WE_n low: TCS + 2*(TWP+TWH)
        run_seq(0, "abort", 4'b0011, 1'b0, 40'h11_22_33_44_55, 16'h0004, 0, 10);
        run_seq(0, "after_abort", 4'b0001, 1'b1, 40'h70_00_00_00_00, 16'h0000, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
